if_id_queue: RTL

- Parametrised successor to the single-stage IF/ID latch: a DEPTH-entry FIFO of fetched instructions sitting between the fetch stage and decode.
- Each entry holds pc, instruction word and fetch exception type.
- Valid/ready handshakes on both sides replace the stall/inst_stall pair.
- Synchronous flush (exception or branch redirect) discards all queued entries.

---
 rtl/if_id_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO of fetched instructions between fetch and decode.
// Optional macro IF_ID_QUEUE_BYPASS_EN passes fetch straight to decode when the queue is empty.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_instr,
  input  logic [EXC_W-1:0]  if_exception_type,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_instr,
  output logic [EXC_W-1:0]  id_exception_type,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [INST_W-1:0] instr_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             nonempty;
  logic             push;
  logic             pop;

  assign nonempty = (count_q != '0);
  // if_ready looks only at registered occupancy so fetch never sees a path from id_ready.
  assign if_ready = (count_q != FULL);
  assign count    = count_q;
  assign pop      = nonempty && id_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass   = !nonempty && if_valid && !flush;
  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign push     = if_valid && if_ready && !(bypass && id_ready);
  assign id_valid = nonempty || bypass;
`else
  assign push     = if_valid && if_ready;
  assign id_valid = nonempty;
`endif

  always_comb begin
    id_pc             = '0;
    id_instr          = '0;
    id_exception_type = '0;
    if (nonempty) begin
      id_pc             = pc_mem[rd_ptr_q];
      id_instr          = instr_mem[rd_ptr_q];
      id_exception_type = exc_mem[rd_ptr_q];
    end
`ifdef IF_ID_QUEUE_BYPASS_EN
    else if (bypass) begin
      id_pc             = if_pc;
      id_instr          = if_instr;
      id_exception_type = if_exception_type;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never reset; stale slots are hidden by the zero bubble when empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]    <= if_pc;
      instr_mem[wr_ptr_q] <= if_instr;
      exc_mem[wr_ptr_q]   <= if_exception_type;
    end
  end

endmodule
